fbw_row_buf: RTL and testbench
==============================

# fbw_row_buf

Row-buffer stage directly downstream of the pattern generator, terminating its frame-buffer write interface. It collects one row of pixels into a ping-pong line buffer and copies each completed row into the frame memory through a write port with a ready handshake. It also arbitrates the end-of-frame swap with the frame memory controller.

## Interface
Parameters:
- COL_W, 6: column address width (64 columns)
- ROW_W, 6: row address width (64 rows)
- PIX_W, 24: pixel width (R[23:16], G[15:8], B[7:0])

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fbw_data  in  PIX_W  pixel to write into the line buffer
- fbw_col_addr  in  COL_W  column of fbw_data
- fbw_wren  in  1  write fbw_data into the current write bank
- fbw_row_addr  in  ROW_W  destination row, sampled with fbw_row_store
- fbw_row_store  in  1  start copy of the current write bank to row fbw_row_addr
- fbw_row_swap  in  1  toggle the write bank
- fbw_row_rdy  out  1  copy engine idle; store accepted
- frame_swap  in  1  request frame swap
- frame_rdy  out  1  frame path idle; new frame may start
- mem_addr  out  ROW_W+COL_W  {row, col}
- mem_data  out  PIX_W  pixel to frame memory
- mem_we  out  1  write request, held until accepted
- mem_rdy  in  1  write accepted when mem_we && mem_rdy
- mem_frame_swap  out  1  one-cycle swap pulse to the memory controller
- mem_frame_done  in  1  memory controller finished swap

## Operation
- Line buffer: 2 banks × 2^COL_W × PIX_W. wr_sel selects the write bank. fbw_wren writes fbw_data at {wr_sel, fbw_col_addr}.
- fbw_row_swap toggles wr_sel at the end of the cycle.
- fbw_row_store, sampled while fbw_row_rdy=1, latches row = fbw_row_addr and src_bank = wr_sel, using the pre-toggle value when swap coincides.
- Store while fbw_row_rdy=0 is dropped.
- Writing into src_bank during a copy corrupts the copy. Sources must swap together with store.
- Copy FSM:
  - IDLE: fbw_row_rdy=1. On an accepted store, col=0 and go to READ.
  - READ: present the RAM read address {src_bank, col}, then go to WRITE.
  - WRITE: mem_we=1, mem_addr={row, col}, mem_data=RAM output, all held stable until mem_rdy. On accept: if col is all-ones go to IDLE, else col+1 and go to READ.
- Frame FSM:
  - F_READY: frame_rdy=1. frame_swap goes to F_DRAIN. frame_swap in any other state is ignored.
  - F_DRAIN: wait until the copy FSM is IDLE and no store is being accepted this cycle, then go to F_SWAP.
  - F_SWAP: mem_frame_swap=1 for exactly one cycle, then go to F_WAIT.
  - F_WAIT: on mem_frame_done, go to F_READY.
- Store and frame_swap in the same cycle: the store is taken and F_DRAIN waits for it to finish.
- Reset values (mid-operation reset aborts everything immediately): wr_sel=0, copy IDLE, frame F_READY, fbw_row_rdy=1, frame_rdy=1, mem_we=0, mem_frame_swap=0, mem_addr=0, mem_data=0. Line RAM contents are not reset.

## Timing
- fbw_row_rdy and frame_rdy are decoded from state registers only, with no combinational path from inputs.
- Store sampled at cycle T:
  - fbw_row_rdy=0 from T+1.
  - First mem_we at T+2 (col 0).
  - With mem_rdy held at 1, one pixel every 2 cycles; col 63 is written at T+128 and fbw_row_rdy=1 at T+129.
  - Each mem_rdy stall cycle adds one cycle.
- RAM read latency is 1 cycle. A wren and a copy read to different banks in the same cycle are both served.
- A frame_swap accepted at T with copy idle gives F_DRAIN at T+1 and mem_frame_swap at T+2. If mem_frame_done arrives at T+k (k≥3), frame_rdy=1 at T+k+1.
- mem_addr/mem_data are registered. mem_we drops the cycle after the last accept.

## Structure
- Package fbw_pkg holds:
  - the copy and frame FSM state localparams;
  - default COL_W/ROW_W/PIX_W;
  - the bank count.
- Sub-module fbw_line_ram: simple dual-port RAM of 2^(COL_W+1) × PIX_W with a synchronous 1-cycle read. The bank is the address MSB. It infers to EBR.
- Everything else (both FSMs, counters, registers) lives in fbw_row_buf.

## Test plan
- Fill bank 0 with pixel=col×0x010203 (wren cols 0..63), then store+swap with row=5 and mem_rdy=1. Expect 64 writes to addr 0x140..0x17F with matching data, first mem_we at T+2, fbw_row_rdy high at T+129, wr_sel=1.
- Random mem_rdy stalls during a copy: mem_addr/mem_data stay stable while mem_we&&!mem_rdy, no pixel is lost or duplicated, and completion is delayed by exactly the stall count.
- Fill bank 1 with the next row while bank 0 is copying: both rows land intact. A second store issued while fbw_row_rdy=0 is ignored, so no extra mem_we.
- Assert frame_swap in the same cycle as a store: mem_frame_swap fires only after the row's last write. frame_rdy=0 until the cycle after mem_frame_done. A frame_swap during F_WAIT causes no second pulse.
- Assert rst mid-copy (col 30): the next cycle shows mem_we=0, fbw_row_rdy=1, frame_rdy=1. A new store then starts cleanly at col 0.

Source files
------------

// File: rtl/fbw_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fbw_pkg : shared sizes and FSM encodings for the frame-buffer writer   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package fbw_pkg;

   localparam int C_COL_W  = 6;
   localparam int C_ROW_W  = 6;
   localparam int C_PIX_W  = 24;
   localparam int C_BANKS  = 2;
   localparam int C_BANK_W = $clog2(C_BANKS);

   // Row copy engine
   localparam logic [1:0] C_CP_IDLE  = 2'd0;
   localparam logic [1:0] C_CP_READ  = 2'd1;
   localparam logic [1:0] C_CP_WRITE = 2'd2;

   // Frame swap arbitration
   localparam logic [1:0] C_FR_READY = 2'd0;
   localparam logic [1:0] C_FR_DRAIN = 2'd1;
   localparam logic [1:0] C_FR_SWAP  = 2'd2;
   localparam logic [1:0] C_FR_WAIT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fbw_line_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fbw_line_ram : simple dual-port line RAM, 1-cycle registered read      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module fbw_line_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Only the output register is reset; the array itself keeps its contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fbw_row_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fbw_row_buf : ping-pong row buffer copying rows into frame memory,     |
// |               plus end-of-frame swap arbitration. Rev 1.0              |
// +-----------------------------------------------------------------------+
module fbw_row_buf
   import fbw_pkg::*;
#(
   parameter int COL_W = C_COL_W,
   parameter int ROW_W = C_ROW_W,
   parameter int PIX_W = C_PIX_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIX_W-1:0]       fbw_data,
   input  logic [COL_W-1:0]       fbw_col_addr,
   input  logic                   fbw_wren,
   input  logic [ROW_W-1:0]       fbw_row_addr,
   input  logic                   fbw_row_store,
   input  logic                   fbw_row_swap,
   output logic                   fbw_row_rdy,
   input  logic                   frame_swap,
   output logic                   frame_rdy,
   output logic [ROW_W+COL_W-1:0] mem_addr,
   output logic [PIX_W-1:0]       mem_data,
   output logic                   mem_we,
   input  logic                   mem_rdy,
   output logic                   mem_frame_swap,
   input  logic                   mem_frame_done
);

   logic [1:0]             r_cp_state;
   logic [1:0]             r_fr_state;
   logic [C_BANK_W-1:0]    r_wr_sel;
   logic [C_BANK_W-1:0]    r_src_bank;
   logic [ROW_W-1:0]       r_row;
   logic [COL_W-1:0]       r_col;
   logic [ROW_W+COL_W-1:0] r_mem_addr;
   logic                   r_mem_we;

   logic                   w_store_acc;
   logic                   w_ram_re;
   logic [PIX_W-1:0]       w_ram_rdata;

   assign w_store_acc = fbw_row_store && (r_cp_state == C_CP_IDLE);
   assign w_ram_re    = (r_cp_state == C_CP_READ);

   fbw_line_ram #(
      .ADDR_W (COL_W + C_BANK_W),
      .DATA_W (PIX_W)
   ) u_line_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (fbw_wren),
      .i_waddr ({r_wr_sel, fbw_col_addr}),
      .i_wdata (fbw_data),
      .i_re    (w_ram_re),
      .i_raddr ({r_src_bank, r_col}),
      .o_rdata (w_ram_rdata)
   );

   // The store captures the bank being written this cycle, before any swap lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_sel <= '0;
      end else if (fbw_row_swap) begin
         r_wr_sel <= r_wr_sel + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cp_state <= C_CP_IDLE;
         r_src_bank <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_mem_addr <= '0;
         r_mem_we   <= 1'b0;
      end else begin
         case (r_cp_state)
            C_CP_IDLE: begin
               if (w_store_acc) begin
                  r_row      <= fbw_row_addr;
                  r_src_bank <= r_wr_sel;
                  r_col      <= '0;
                  r_cp_state <= C_CP_READ;
               end
            end
            C_CP_READ: begin
               r_mem_addr <= {r_row, r_col};
               r_mem_we   <= 1'b1;
               r_cp_state <= C_CP_WRITE;
            end
            C_CP_WRITE: begin
               // Address, data and request hold until the memory takes them.
               if (mem_rdy) begin
                  r_mem_we <= 1'b0;
                  if (&r_col) begin
                     r_cp_state <= C_CP_IDLE;
                  end else begin
                     r_col      <= r_col + 1'b1;
                     r_cp_state <= C_CP_READ;
                  end
               end
            end
            default: begin
               r_cp_state <= C_CP_IDLE;
               r_mem_we   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fr_state <= C_FR_READY;
      end else begin
         case (r_fr_state)
            C_FR_READY: begin
               if (frame_swap) begin
                  r_fr_state <= C_FR_DRAIN;
               end
            end
            C_FR_DRAIN: begin
               // A store arriving this cycle must finish before the swap.
               if ((r_cp_state == C_CP_IDLE) && !w_store_acc) begin
                  r_fr_state <= C_FR_SWAP;
               end
            end
            C_FR_SWAP: begin
               r_fr_state <= C_FR_WAIT;
            end
            default: begin
               if (mem_frame_done) begin
                  r_fr_state <= C_FR_READY;
               end
            end
         endcase
      end
   end

   assign fbw_row_rdy    = (r_cp_state == C_CP_IDLE);
   assign frame_rdy      = (r_fr_state == C_FR_READY);
   assign mem_frame_swap = (r_fr_state == C_FR_SWAP);
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_data       = w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_fbw_row_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fbw_row_buf : directed scoreboard bench for fbw_row_buf             |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_fbw_row_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] fbw_data = '0;
   logic [5:0]  fbw_col_addr = '0;
   logic        fbw_wren = 1'b0;
   logic [5:0]  fbw_row_addr = '0;
   logic        fbw_row_store = 1'b0;
   logic        fbw_row_swap = 1'b0;
   logic        fbw_row_rdy;
   logic        frame_swap = 1'b0;
   logic        frame_rdy;
   logic [11:0] mem_addr;
   logic [23:0] mem_data;
   logic        mem_we;
   logic        mem_rdy = 1'b1;
   logic        mem_frame_swap;
   logic        mem_frame_done = 1'b0;

   fbw_row_buf dut (
      .clk            (clk),
      .rst            (rst),
      .fbw_data       (fbw_data),
      .fbw_col_addr   (fbw_col_addr),
      .fbw_wren       (fbw_wren),
      .fbw_row_addr   (fbw_row_addr),
      .fbw_row_store  (fbw_row_store),
      .fbw_row_swap   (fbw_row_swap),
      .fbw_row_rdy    (fbw_row_rdy),
      .frame_swap     (frame_swap),
      .frame_rdy      (frame_rdy),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_we         (mem_we),
      .mem_rdy        (mem_rdy),
      .mem_frame_swap (mem_frame_swap),
      .mem_frame_done (mem_frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_vec = 0;
   int          n_fail = 0;
   logic [35:0] sb[$];
   bit          stall_mode = 0;
   int          stalls = 0;
   int          swap_cnt = 0;
   int          swap_cyc = -1;
   int          first_we = -1;
   bit          pending = 0;
   bit          prev_rdy = 1;
   bit          prev_stall = 0;
   logic [11:0] prev_addr = '0;
   logic [23:0] prev_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pat(input int id, input int c);
      logic [23:0] cc;
      cc = 24'(c);
      case (id)
         1:       pat = cc * 24'h010203;
         2:       pat = 24'hA00000 | (cc * 24'h000105);
         default: pat = 24'h0F0F0F ^ (cc * 24'h030201);
      endcase
   endfunction

   task automatic push_row(input int id, input int row);
      logic [5:0] r6;
      logic [5:0] c6;
      r6 = row[5:0];
      for (int c = 0; c < 64; c++) begin
         c6 = c[5:0];
         sb.push_back({r6, c6, pat(id, c)});
      end
   endtask

   // Observes the write port mid-cycle, then advances one clock.
   task automatic tick();
      logic [35:0] e;
      @(negedge clk);
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_we", mem_we, 1);
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_data", mem_data, prev_data);
         end
         if (prev_rdy && !fbw_row_rdy) pending = 1;
         if (pending && mem_we) begin
            first_we = cyc;
            pending  = 0;
         end
         if (mem_we && mem_rdy) begin
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("wr_addr", mem_addr, e[35:24]);
               chk("wr_data", mem_data, e[23:0]);
            end
         end
         if (mem_we && !mem_rdy) stalls++;
         if (mem_frame_swap) begin
            swap_cnt++;
            swap_cyc = cyc;
         end
         prev_stall = mem_we && !mem_rdy;
      end else begin
         prev_stall = 0;
         pending    = 0;
      end
      prev_rdy  = fbw_row_rdy;
      prev_addr = mem_addr;
      prev_data = mem_data;
      @(posedge clk);
      #1;
      if (stall_mode) mem_rdy = ($urandom_range(0, 2) != 0);
   endtask

   task automatic fill(input int id);
      for (int c = 0; c < 64; c++) begin
         fbw_wren     = 1;
         fbw_col_addr = c[5:0];
         fbw_data     = pat(id, c);
         tick();
      end
      fbw_wren = 0;
   endtask

   task automatic wait_rdy(output int at);
      int n;
      n = 0;
      while (!fbw_row_rdy && n < 400) begin
         tick();
         n++;
      end
      chk("rdy_timeout", fbw_row_rdy, 1);
      at = cyc;
   endtask

   initial begin
      int t, at, s0, d, n;

      // Reset state
      repeat (3) tick();
      chk("rst_row_rdy", fbw_row_rdy, 1);
      chk("rst_frame_rdy", frame_rdy, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_swap", mem_frame_swap, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      rst = 0;
      tick();

      // Row 5 from bank 0, no stalls
      fill(1);
      push_row(1, 5);
      t = cyc;
      fbw_row_addr = 6'd5; fbw_row_store = 1; fbw_row_swap = 1;
      tick();
      fbw_row_store = 0; fbw_row_swap = 0;
      chk("row_rdy_low", fbw_row_rdy, 0);
      wait_rdy(at);
      chk("first_we_cyc", first_we, t + 2);
      chk("row_done_cyc", at, t + 129);
      chk("sb_empty_1", sb.size(), 0);

      // Row 9 from bank 1 with random stalls; bank 0 refilled meanwhile
      fill(2);
      push_row(2, 9);
      stall_mode = 1;
      s0 = stalls;
      t = cyc;
      fbw_row_addr = 6'd9; fbw_row_store = 1; fbw_row_swap = 1;
      tick();
      fbw_row_store = 0; fbw_row_swap = 0;
      for (int c = 0; c < 64; c++) begin
         fbw_wren     = 1;
         fbw_col_addr = c[5:0];
         fbw_data     = pat(3, c);
         if (c == 10) begin
            fbw_row_addr  = 6'd20;
            fbw_row_store = 1;
         end
         tick();
         fbw_row_store = 0;
      end
      fbw_wren = 0;
      wait_rdy(at);
      chk("stall_done_cyc", at, t + 129 + (stalls - s0));
      stall_mode = 0;
      mem_rdy = 1;
      repeat (4) tick();
      chk("sb_empty_2", sb.size(), 0);

      // Row 10 from bank 0 with frame swap in the same cycle
      push_row(3, 10);
      s0 = swap_cnt;
      t = cyc;
      fbw_row_addr = 6'd10; fbw_row_store = 1; fbw_row_swap = 1; frame_swap = 1;
      tick();
      fbw_row_store = 0; fbw_row_swap = 0; frame_swap = 0;
      chk("frame_rdy_drain", frame_rdy, 0);
      wait_rdy(at);
      chk("row10_done_cyc", at, t + 129);
      chk("sb_empty_3", sb.size(), 0);
      n = 0;
      while (swap_cnt == s0 && n < 10) begin
         tick();
         n++;
      end
      chk("swap_cyc", swap_cyc, t + 130);
      frame_swap = 1;
      tick();
      frame_swap = 0;
      repeat (3) tick();
      chk("swap_once", swap_cnt, s0 + 1);
      chk("frame_rdy_wait", frame_rdy, 0);
      mem_frame_done = 1;
      d = cyc;
      chk("frame_rdy_at_done", frame_rdy, 0);
      tick();
      mem_frame_done = 0;
      chk("frame_rdy_after", frame_rdy, 1);
      chk("frame_rdy_cyc", cyc, d + 1);

      // Reset in the middle of a copy, then a clean restart
      push_row(2, 30);
      fbw_row_addr = 6'd30; fbw_row_store = 1;
      tick();
      fbw_row_store = 0;
      n = 0;
      while (!(mem_we && mem_addr[5:0] == 6'd30) && n < 200) begin
         tick();
         n++;
      end
      chk("reach_col30", mem_addr[5:0], 30);
      rst = 1;
      tick();
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_row_rdy", fbw_row_rdy, 1);
      chk("mid_rst_frame_rdy", frame_rdy, 1);
      sb.delete();
      rst = 0;
      tick();
      push_row(3, 31);
      t = cyc;
      fbw_row_addr = 6'd31; fbw_row_store = 1;
      tick();
      fbw_row_store = 0;
      wait_rdy(at);
      chk("restart_first_we", first_we, t + 2);
      chk("restart_done_cyc", at, t + 129);
      chk("sb_empty_4", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
